// File: rtl/c3_heap_pkg.sv
// rtl/c3_heap_pkg.sv - shared constants for the heap-instruction writeback slice
//
// Purpose: heap op-code constants, register-address width and a small decode
// helper shared by c3_heap_writeback and its result FIFO.
// Ports: none (package).

package c3_heap_pkg;

  localparam int RD_W = 5;

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;

  // Only the two defined ops move the architectural heap size; reserved
  // encodings still write back but leave heap_size_q alone.
  function automatic logic op_updates_size(input logic [2:0] op);
    return (op == OP_PUSH) || (op == OP_POP);
  endfunction

endpackage

// File: rtl/c3_heap_wb_fifo.sv
// rtl/c3_heap_wb_fifo.sv - result queue between heap stage and register-file write port
//
// Purpose: DEPTH-entry FIFO holding {rd, data} writeback entries.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   push, push_data   enqueue request and entry (caller guarantees room or a same-cycle pop)
//   pop               dequeue the head entry
//   out_v, out_data   head entry valid / head entry
//   count             registered occupancy, clog2(DEPTH)+1 bits
//   full              count == DEPTH

module c3_heap_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic          out_v,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] count,
  output logic          full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // DEPTH is a power of two, so plain AW-bit increments wrap modulo DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is intentionally left unreset; out_v gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign out_v    = (count != '0);
  assign out_data = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));

endmodule

// File: rtl/c3_heap_writeback.sv
// rtl/c3_heap_writeback.sv - heap-instruction result writeback with queue and heap-size register
//
// Purpose: accepts results from the heap instruction stage, selects the
// write value per op, tracks the architectural heap size, queues register-file
// writes and flags dropped results. Optional same-cycle bypass when the queue
// is empty is enabled by defining C3_HEAP_WB_BYPASS_EN.
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   in_v, in_rd, in_op             result valid, destination register, op code
//   in_data, in_heap_size          popped value, post-operation heap size
//   stall                          issue-hold request (queue has <= 1 free slot)
//   wb_v, wb_ready, wb_rd, wb_data register-file write handshake
//   heap_size_q                    architectural heap-size register
//   ovf                            sticky overflow (result dropped on full queue)

module c3_heap_writeback
  import c3_heap_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_v,
  input  logic [RD_W-1:0] in_rd,
  input  logic [2:0]      in_op,
  input  logic [DW-1:0]   in_data,
  input  logic [DW-1:0]   in_heap_size,
  output logic            stall,
  output logic            wb_v,
  input  logic            wb_ready,
  output logic [RD_W-1:0] wb_rd,
  output logic [DW-1:0]   wb_data,
  output logic [DW-1:0]   heap_size_q,
  output logic            ovf
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = RD_W + DW;

  logic          fifo_v;
  logic          fifo_full;
  logic          fifo_pop;
  logic          fifo_push;
  logic          accept;
  logic          bypass;
  logic [DW-1:0] wr_val;
  logic [EW-1:0] fifo_out;
  logic [CW-1:0] count;

  assign wr_val   = (in_op == OP_PUSH) ? in_heap_size : in_data;
  assign fifo_pop = fifo_v && wb_ready;
  // A full queue still takes a new result when the head leaves this cycle.
  assign accept   = in_v && (!fifo_full || fifo_pop);

`ifdef C3_HEAP_WB_BYPASS_EN
  assign bypass  = in_v && !fifo_v && wb_ready && (in_rd != '0);
  assign wb_v    = fifo_v || bypass;
  assign wb_rd   = bypass ? in_rd  : fifo_out[EW-1:DW];
  assign wb_data = bypass ? wr_val : fifo_out[DW-1:0];
`else
  assign bypass  = 1'b0;
  assign wb_v    = fifo_v;
  assign wb_rd   = fifo_out[EW-1:DW];
  assign wb_data = fifo_out[DW-1:0];
`endif

  // Writes to x0 are architecturally discarded, so they never occupy a slot.
  assign fifo_push = accept && (in_rd != '0) && !bypass;

  // Registered count only: upstream sees no combinational path from in_v.
  assign stall = (count >= CW'(DEPTH - 1));

  c3_heap_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({in_rd, wr_val}),
    .pop       (fifo_pop),
    .out_v     (fifo_v),
    .out_data  (fifo_out),
    .count     (count),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      heap_size_q <= '0;
      ovf         <= 1'b0;
    end else begin
      if (accept && op_updates_size(in_op)) heap_size_q <= in_heap_size;
      if (in_v && fifo_full && !fifo_pop)   ovf         <= 1'b1;
    end
  end

endmodule

// File: tb/tb_c3_heap_writeback.sv
// tb/tb_c3_heap_writeback.sv - scoreboard bench for c3_heap_writeback

module tb_c3_heap_writeback;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  typedef struct {
    logic [4:0]    rd;
    logic [DW-1:0] d;
  } wb_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_v = 1'b0;
  logic [4:0]    in_rd = '0;
  logic [2:0]    in_op = '0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] in_heap_size = '0;
  logic          stall;
  logic          wb_v;
  logic          wb_ready = 1'b0;
  logic [4:0]    wb_rd;
  logic [DW-1:0] wb_data;
  logic [DW-1:0] heap_size_q;
  logic          ovf;

  c3_heap_writeback #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_v         (in_v),
    .in_rd        (in_rd),
    .in_op        (in_op),
    .in_data      (in_data),
    .in_heap_size (in_heap_size),
    .stall        (stall),
    .wb_v         (wb_v),
    .wb_ready     (wb_ready),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .heap_size_q  (heap_size_q),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  wb_t           sb[$];
  int            mc = 0;
  logic [DW-1:0] mh = '0;
  logic          mo = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check just after, then advance the model.
  task automatic cyc(input logic v, input logic [2:0] op, input logic [4:0] rd,
                     input logic [DW-1:0] d, input logic [DW-1:0] sz, input logic rdy);
    logic          pop_m, full_m, acc, byp;
    logic [DW-1:0] val;
    wb_t           e;
    @(negedge clk);
    in_v = v; in_op = op; in_rd = rd; in_data = d; in_heap_size = sz; wb_ready = rdy;
    #1;
    val    = (op == 3'b000) ? sz : d;
    pop_m  = (mc != 0) && rdy;
    full_m = (mc == DEPTH);
    acc    = v && (!full_m || pop_m);
`ifdef C3_HEAP_WB_BYPASS_EN
    byp = (mc == 0) && rdy && v && (rd != 0);
`else
    byp = 1'b0;
`endif
    chk("stall", stall, (mc >= DEPTH - 1));
    chk("heap_size_q", heap_size_q, mh);
    chk("ovf", ovf, mo);
    chk("wb_v", wb_v, (mc != 0) || byp);
    if (pop_m) begin
      e = sb.pop_front();
      chk("wb_rd", wb_rd, e.rd);
      chk("wb_data", wb_data, e.d);
    end else if (byp) begin
      chk("byp_rd", wb_rd, rd);
      chk("byp_data", wb_data, val);
    end
    if (acc && rd != 0 && !byp) begin
      e.rd = rd; e.d = val;
      sb.push_back(e);
      mc++;
    end
    if (pop_m) mc--;
    if (acc && op <= 3'b001) mh = sz;
    if (v && full_m && !pop_m) mo = 1'b1;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'b000, 5'd0, '0, '0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; in_v = 1'b0;
    #1;
    chk("rst_wb_v", wb_v, 1'b0);
    chk("rst_heap", heap_size_q, '0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    sb.delete(); mc = 0; mh = '0; mo = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    do_reset();
    idle(1'b1, 1);

    // push op, rd=5, size=7: visible next cycle
    cyc(1'b1, 3'b000, 5'd5, 32'hDEAD, 32'd7, 1'b0);
    idle(1'b1, 1);
    // pop op, rd=3, data=0x2A, size=6
    cyc(1'b1, 3'b001, 5'd3, 32'h2A, 32'd6, 1'b1);
    idle(1'b1, 1);

    // backpressure: four fill, fifth overflows, then drain in order
    for (int i = 0; i < 5; i++)
      cyc(1'b1, i[2:0] & 3'b001, 5'(i + 10), 32'(100 + i), 32'(20 + i), 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 5);

    // reset with three queued entries
    for (int i = 0; i < 3; i++) cyc(1'b1, 3'b000, 5'(i + 1), '0, 32'(40 + i), 1'b0);
    do_reset();
    idle(1'b1, 2);

    // full queue, push and pop together
    for (int i = 0; i < 4; i++) cyc(1'b1, 3'b001, 5'(i + 20), 32'(200 + i), 32'(i), 1'b0);
    cyc(1'b1, 3'b001, 5'd30, 32'h300, 32'd50, 1'b1);
    idle(1'b0, 1);
    // one entry in flight with push+pop together
    idle(1'b1, 3);
    cyc(1'b1, 3'b000, 5'd31, '0, 32'd60, 1'b1);
    idle(1'b1, 3);

    // rd=0 does not write; reserved op keeps heap size
    cyc(1'b1, 3'b000, 5'd0, '0, 32'd9, 1'b1);
    idle(1'b1, 1);
    cyc(1'b1, 3'b010, 5'd7, 32'h55, 32'd99, 1'b1);
    idle(1'b1, 2);

    // mixed random traffic
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
          $urandom, $urandom, 1'($urandom_range(0, 1)));
    idle(1'b1, DEPTH + 2);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/c3_heap_writeback.md
C3_HEAP_WRITEBACK -- requirements
Module: c3_heap_writeback

Interface
REQ-001 Parameter DEPTH, default 4, result-queue entries; power of two, 2..16.
REQ-002 Parameter DW, default 32, data and heap-size width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 in_v  in  1  result valid from heap instruction stage.
REQ-006 in_rd  in  5  destination register.
REQ-007 in_op  in  3  heap op code: 000 pushHeap, 001 popHeap, others reserved.
REQ-008 in_data  in  DW  popped value.
REQ-009 in_heap_size  in  DW  post-operation heap size.
REQ-010 stall  out  1  issue-hold request to upstream.
REQ-011 wb_v  out  1  register-file write valid.
REQ-012 wb_ready  in  1  register file accepts write.
REQ-013 wb_rd  out  5  write address.
REQ-014 wb_data  out  DW  write data.
REQ-015 heap_size_q  out  DW  architectural heap-size register.
REQ-016 ovf  out  1  sticky overflow flag.

Function
REQ-017 Accept: in_v high and queue not full, or in_v high, queue full and pop in same cycle.
REQ-018 Write value: op 000 -> in_heap_size; op 001 -> in_data; reserved ops -> in_data.
REQ-019 Accepted result with in_rd==0 is not enqueued; heap_size_q still updates.
REQ-020 heap_size_q <= in_heap_size on every accepted op 000/001; reserved ops leave it unchanged.
REQ-021 Enqueued entry appears on wb_v/wb_rd/wb_data the cycle after acceptance; FIFO order preserved.
REQ-022 Pop when wb_v && wb_ready; wb_rd/wb_data stay stable while wb_v && !wb_ready.
REQ-023 Same-cycle push and pop: count unchanged, both take effect, including at full and at one entry.
REQ-024 Count width clog2(DEPTH)+1; read/write pointers wrap modulo DEPTH.
REQ-025 stall = registered count >= DEPTH-1; no combinational path from in_v.
REQ-026 in_v while full with no pop: result dropped, heap_size_q unchanged, ovf set on next edge until reset.
REQ-027 wb_v = queue not empty; wb_v is not gated by wb_ready.

Reset
REQ-028 While reset low: count, pointers, wb_v, ovf, stall = 0, heap_size_q = 0.
REQ-029 Reset mid-operation discards all queued entries; no write issued in the release cycle.
REQ-030 Queue storage is not required to be reset.

Configuration
REQ-031 C3_HEAP_WB_BYPASS_EN defined: queue empty, wb_ready high and acceptable in_v with in_rd!=0 -> result driven on wb_* in the same cycle, not enqueued.
REQ-032 C3_HEAP_WB_BYPASS_EN undefined: every result incurs the REQ-021 one-cycle latency; no in_* -> wb_* combinational path.

Structure
REQ-033 Package c3_heap_pkg holds the op-code constants (OP_PUSH=3'b000, OP_POP=3'b001) and the register-address width.
REQ-034 Storage and pointers live in sub-module c3_heap_wb_fifo (DEPTH, width 5+DW); top-level holds op decode, heap_size_q, ovf, bypass.

Verification
REQ-035 After reset, op 000 rd=5 size=7 -> next cycle wb_v=1, wb_rd=5, wb_data=7; heap_size_q=7.
REQ-036 op 001 rd=3 data=0x2A size=6, wb_ready=1 -> wb_data=0x2A, heap_size_q=6, entry popped.
REQ-037 wb_ready=0 with 4 pushes (DEPTH=4) -> stall=1 after third, fifth push sets ovf=1; release wb_ready -> four writes drain in order.
REQ-038 Full queue, in_v and wb_ready high in same cycle -> new entry accepted, count stays 4, ovf stays 0.
REQ-039 op 000 rd=0 size=9 -> no wb_v, heap_size_q=9.
REQ-040 Reset asserted with 3 queued entries -> wb_v=0 immediately, heap_size_q=0; with C3_HEAP_WB_BYPASS_EN defined, empty queue and wb_ready=1 -> wb_v in same cycle as in_v.
